// File: rtl/hamming_bpsk_framer_pkg.sv
// rtl/hamming_bpsk_framer_pkg.sv - shared transceiver constants, FSM state encoding and helpers
package hamming_bpsk_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2
    } state_t;

    // Codeword width is shared with the Hamming encoder and decoder.
    localparam int         CODEWORD_WIDTH        = 12;
    localparam int         DEFAULT_PREAMBLE_BITS = 8;
    localparam logic [7:0] DEFAULT_PREAMBLE      = 8'hD5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hamming_bpsk_framer_if.sv
// rtl/hamming_bpsk_framer_if.sv - codeword input handshake and symbol output bundle
interface hamming_bpsk_framer_if
    import hamming_bpsk_framer_pkg::*;
#(
    parameter int DATA_WIDTH = CODEWORD_WIDTH
) ();

    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  sym_bit;
    logic                  sym_valid;
    logic                  sym_strobe;
    logic                  frame_start;
    logic                  busy;

    modport master (
        output s_valid, s_data,
        input  s_ready, sym_bit, sym_valid, sym_strobe, frame_start, busy
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, sym_bit, sym_valid, sym_strobe, frame_start, busy
    );

endinterface

// File: rtl/hamming_bpsk_framer_sync_fifo.sv
// rtl/hamming_bpsk_framer_sync_fifo.sv - power-of-two synchronous FIFO with registered read
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_rd_data;
    logic             w_push;
    logic             w_pop;

    assign full    = (r_count == CNT_W'(DEPTH));
    assign empty   = (r_count == '0);
    assign w_push  = wr_en && !full;
    assign w_pop   = rd_en && !empty;
    assign rd_data = r_rd_data;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/hamming_bpsk_framer.sv
// rtl/hamming_bpsk_framer.sv - buffers Hamming codewords and serializes them behind a preamble for BPSK
module hamming_bpsk_framer
    import hamming_bpsk_framer_pkg::*;
#(
    parameter int                       DATA_WIDTH         = CODEWORD_WIDTH,
    parameter int                       FIFO_DEPTH         = 4,
    parameter int                       SAMPLES_PER_SYMBOL = 256,
    parameter int                       PREAMBLE_BITS      = DEFAULT_PREAMBLE_BITS,
    parameter logic [PREAMBLE_BITS-1:0] PREAMBLE           = PREAMBLE_BITS'(DEFAULT_PREAMBLE)
) (
    input logic                   clk,
    input logic                   rst,
    hamming_bpsk_framer_if.slave  bus
);

    localparam int SHIFT_W = max_int(PREAMBLE_BITS, DATA_WIDTH);
    localparam int CNT_W   = $clog2(SAMPLES_PER_SYMBOL);
    localparam int BIT_W   = $clog2(SHIFT_W);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_sample_cnt;
    logic [CNT_W-1:0]    w_sample_cnt_nxt;
    logic [BIT_W-1:0]    r_bit_idx;
    logic [BIT_W-1:0]    w_bit_idx_nxt;
    logic [SHIFT_W-1:0]  r_shift;
    logic [SHIFT_W-1:0]  w_shift_nxt;
    logic                r_sym_valid;
    logic                w_sym_valid_nxt;
    logic                r_sym_strobe;
    logic                w_sym_strobe_nxt;
    logic                r_frame_start;
    logic                w_frame_start_nxt;
    logic                r_busy;
    logic                w_start;
    logic                w_pop;
    logic                w_wr_en;
    logic                w_full;
    logic                w_empty;
    logic                w_last_sample;
    logic                w_last_bit;
    logic [DATA_WIDTH-1:0] w_fifo_data;
    logic [SHIFT_W-1:0]  w_preamble_load;
    logic [SHIFT_W-1:0]  w_data_load;

    assign bus.s_ready     = !w_full && !rst;
    assign w_wr_en         = bus.s_valid && bus.s_ready;
    assign w_last_sample   = (r_sample_cnt == CNT_W'(SAMPLES_PER_SYMBOL - 1));
    assign w_last_bit      = (r_bit_idx == '0);
    // Both patterns are MSB-aligned so the transmitted bit is always r_shift's MSB.
    assign w_preamble_load = SHIFT_W'(PREAMBLE) << (SHIFT_W - PREAMBLE_BITS);
    assign w_data_load     = SHIFT_W'(w_fifo_data) << (SHIFT_W - DATA_WIDTH);

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en),
        .wr_data (bus.s_data),
        .rd_en   (w_pop),
        .rd_data (w_fifo_data),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_comb begin
        w_state_nxt       = r_state;
        w_sample_cnt_nxt  = r_sample_cnt;
        w_bit_idx_nxt     = r_bit_idx;
        w_shift_nxt       = r_shift;
        w_sym_valid_nxt   = r_sym_valid;
        w_sym_strobe_nxt  = 1'b0;
        w_frame_start_nxt = 1'b0;
        w_start           = 1'b0;
        w_pop             = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_sym_valid_nxt = 1'b0;
                w_start         = !w_empty;
            end
            ST_PREAMBLE, ST_DATA: begin
                if (!w_last_sample) begin
                    w_sample_cnt_nxt = r_sample_cnt + 1'b1;
                end else begin
                    w_sample_cnt_nxt = '0;
                    w_sym_strobe_nxt = 1'b1;
                    if (!w_last_bit) begin
                        w_bit_idx_nxt = r_bit_idx - 1'b1;
                        w_shift_nxt   = r_shift << 1;
                    end else if (r_state == ST_PREAMBLE) begin
                        // The codeword was popped at frame start; the registered FIFO read still holds it.
                        w_state_nxt   = ST_DATA;
                        w_bit_idx_nxt = BIT_W'(DATA_WIDTH - 1);
                        w_shift_nxt   = w_data_load;
                    end else if (!w_empty) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_nxt      = ST_IDLE;
                        w_sym_valid_nxt  = 1'b0;
                        w_sym_strobe_nxt = 1'b0;
                        w_bit_idx_nxt    = '0;
                        w_shift_nxt      = '0;
                    end
                end
            end
            default: begin
                w_state_nxt      = ST_IDLE;
                w_sym_valid_nxt  = 1'b0;
                w_sample_cnt_nxt = '0;
                w_bit_idx_nxt    = '0;
                w_shift_nxt      = '0;
            end
        endcase

        if (w_start) begin
            w_pop             = 1'b1;
            w_state_nxt       = ST_PREAMBLE;
            w_sample_cnt_nxt  = '0;
            w_bit_idx_nxt     = BIT_W'(PREAMBLE_BITS - 1);
            w_shift_nxt       = w_preamble_load;
            w_sym_valid_nxt   = 1'b1;
            w_sym_strobe_nxt  = 1'b1;
            w_frame_start_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_sample_cnt  <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_sym_valid   <= 1'b0;
            r_sym_strobe  <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sample_cnt  <= w_sample_cnt_nxt;
            r_bit_idx     <= w_bit_idx_nxt;
            r_shift       <= w_shift_nxt;
            r_sym_valid   <= w_sym_valid_nxt;
            r_sym_strobe  <= w_sym_strobe_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_busy        <= (w_state_nxt != ST_IDLE);
        end
    end

    assign bus.sym_bit     = r_shift[SHIFT_W-1];
    assign bus.sym_valid   = r_sym_valid;
    assign bus.sym_strobe  = r_sym_strobe;
    assign bus.frame_start = r_frame_start;
    assign bus.busy        = r_busy;

endmodule

// File: tb/tb_hamming_bpsk_framer.sv
// tb/tb_hamming_bpsk_framer.sv - scoreboard bench for hamming_bpsk_framer with a bit-list reference model
module tb_hamming_bpsk_framer;

    localparam int         DW  = 12;
    localparam int         SPS = 4;
    localparam int         PB  = 8;
    localparam logic [7:0] PRE = 8'hD5;
    localparam int         FL  = (PB + DW) * SPS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hamming_bpsk_framer_if #(.DATA_WIDTH(DW)) bus ();

    hamming_bpsk_framer #(
        .DATA_WIDTH         (DW),
        .FIFO_DEPTH         (4),
        .SAMPLES_PER_SYMBOL (SPS),
        .PREAMBLE_BITS      (PB),
        .PREAMBLE           (PRE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic b;
        logic fs;
    } exp_t;

    exp_t exp_q[$];
    int   fs_pos[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   hc       = 0;
    int   run_len  = 0;
    int   last_run = 0;
    int   n_strobe = 0;
    int   n_fs     = 0;
    logic cur_bit  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // A frame is the preamble bits followed by the codeword bits, both MSB first.
    function automatic void model_push(input logic [DW-1:0] w);
        logic [PB-1:0] p;
        p = PRE;
        for (int i = PB - 1; i >= 0; i--) exp_q.push_back('{p[i], (i == PB - 1)});
        for (int i = DW - 1; i >= 0; i--) exp_q.push_back('{w[i], 1'b0});
    endfunction

    task automatic push(input logic [DW-1:0] w, input string name);
        int t;
        t = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        while (!bus.s_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_accept"}, int'(t < 500), 1);
        if (t < 500) model_push(w);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((bus.busy || exp_q.size() != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_idle"}, int'(t < 2000), 1);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hc      = 0;
            run_len = 0;
        end else if (bus.sym_valid) begin
            chk("busy_while_valid", bus.busy, 1);
            if (bus.frame_start) begin
                fs_pos.push_back(run_len);
                n_fs++;
            end
            if (bus.sym_strobe) begin
                exp_t e;
                if (hc != 0) chk("symbol_hold", hc, SPS);
                n_strobe++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_symbol", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sym_bit", bus.sym_bit, e.b);
                    chk("frame_start", bus.frame_start, e.fs);
                    cur_bit = e.b;
                end
                hc = 1;
            end else begin
                if (hc == 0) chk("strobe_at_symbol_start", 0, 1);
                chk("bit_stable", bus.sym_bit, cur_bit);
                chk("frame_start_mid_symbol", bus.frame_start, 0);
                hc++;
            end
            run_len++;
        end else begin
            if (hc != 0) chk("symbol_hold_at_end", hc, SPS);
            if (run_len != 0) last_run = run_len;
            hc      = 0;
            run_len = 0;
            chk("strobe_while_idle", bus.sym_strobe, 0);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s0;
        int f0;
        int t;
        int acc;
        logic prev_stall;
        logic first_stall;
        logic [DW-1:0] w3[6];
        logic [DW-1:0] tmp;

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        rst         = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_s_ready", bus.s_ready, 0);
        chk("reset_sym_valid", bus.sym_valid, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_frame_start", bus.frame_start, 0);
        chk("reset_sym_strobe", bus.sym_strobe, 0);
        chk("reset_sym_bit", bus.sym_bit, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("release_s_ready", bus.s_ready, 1);
        chk("release_sym_valid", bus.sym_valid, 0);

        // single word, latency and frame length
        s0 = n_strobe;
        f0 = n_fs;
        fs_pos.delete();
        push(12'hA5C, "t1");
        chk("t1_latency_1clk", bus.sym_valid, 0);
        @(negedge clk);
        chk("t1_latency_2clk", bus.sym_valid, 1);
        wait_idle("t1");
        chk("t1_valid_run", last_run, FL);
        chk("t1_strobes", n_strobe - s0, PB + DW);
        chk("t1_frame_starts", n_fs - f0, 1);

        // back-to-back frames
        fs_pos.delete();
        push(12'hFFF, "t2a");
        push(12'h000, "t2b");
        wait_idle("t2");
        chk("t2_valid_run", last_run, 2 * FL);
        chk("t2_fs_count", fs_pos.size(), 2);
        if (fs_pos.size() == 2) begin
            chk("t2_fs_pos0", fs_pos[0], 0);
            chk("t2_fs_pos1", fs_pos[1], FL);
        end

        // backpressure with the FIFO full
        for (int i = 0; i < 6; i++) begin
            tmp   = 12'($urandom);
            w3[i] = {tmp[DW-1:3], 3'(i)};
        end
        f0 = n_fs;
        push(12'($urandom), "t3_first");
        repeat (10) @(negedge clk);
        acc         = 0;
        t           = 0;
        prev_stall  = 1'b0;
        first_stall = 1'b1;
        bus.s_valid = 1'b1;
        while (acc < 6 && t < 1500) begin
            bus.s_data = w3[acc];
            if (bus.s_ready) begin
                if (prev_stall) chk("t3_ready_after_pop", bus.frame_start, 1);
                model_push(w3[acc]);
                acc++;
                prev_stall = 1'b0;
            end else begin
                if (first_stall) chk("t3_ready_drop_at_full", acc, 4);
                first_stall = 1'b0;
                prev_stall  = 1'b1;
            end
            @(negedge clk);
            t++;
        end
        bus.s_valid = 1'b0;
        chk("t3_all_accepted", acc, 6);
        wait_idle("t3");
        chk("t3_valid_run", last_run, 7 * FL);
        chk("t3_frame_starts", n_fs - f0, 7);

        // reset in the middle of a frame with words still buffered
        push(12'h3C3, "t4a");
        push(12'h5A5, "t4b");
        t = 0;
        while (run_len < 30 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("t4_reach_clock30", int'(t < 500), 1);
        #2 rst = 1'b1;
        #1;
        chk("t4_async_sym_valid", bus.sym_valid, 0);
        chk("t4_async_busy", bus.busy, 0);
        chk("t4_async_s_ready", bus.s_ready, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        s0  = n_strobe;
        @(negedge clk);
        chk("t4_release_s_ready", bus.s_ready, 1);
        chk("t4_release_busy", bus.busy, 0);
        repeat (100) @(negedge clk);
        chk("t4_no_output_after_reset", n_strobe - s0, 0);
        chk("t4_still_idle", bus.busy, 0);

        // push coinciding with the pop of the last buffered word
        fs_pos.delete();
        push(12'h1F0, "t5a");
        push(12'h0E7, "t5b");
        t = 0;
        while (run_len != FL - 1 && t < 500) begin
            @(posedge clk);
            t++;
        end
        chk("t5_reach_frame_end", int'(t < 500), 1);
        @(negedge clk);
        chk("t5_ready_before_pop", bus.s_ready, 1);
        bus.s_valid = 1'b1;
        bus.s_data  = 12'hB2D;
        model_push(12'hB2D);
        @(negedge clk);
        bus.s_valid = 1'b0;
        chk("t5_ready_after_push_pop", bus.s_ready, 1);
        wait_idle("t5");
        chk("t5_valid_run", last_run, 3 * FL);
        chk("t5_fs_count", fs_pos.size(), 3);
        if (fs_pos.size() == 3) chk("t5_fs_pos2", fs_pos[2], 2 * FL);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
